// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_ctrl_pkg;

  // Width of the post-redirect bubble counter (covers FLUSH_DEPTH 1..7).
  localparam int FLUSH_CNT_W = 3;

  // Default number of IF/ID bubbles inserted after a redirect.
  localparam int DEFAULT_FLUSH_DEPTH = 1;

  typedef enum logic [2:0] {
    BOOT     = 3'd0,
    RUN      = 3'd1,
    STALL    = 3'd2,
    REDIRECT = 3'd3,
    HALT     = 3'd4
  } state_t;

endpackage

// File: rtl/fetch_control_sat_counter.sv
// Saturating up-counter used for the fetch performance counters.
// Sticks at all-ones once reached and never wraps.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, holding at all-ones; synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_control.sv
// Instruction-fetch sequencer: PC write enable, next-PC select and IF/ID
// control, arbitrating halt > redirect > hazard stall.
//
// Request semantics: branch_taken, hazard_stall and halt_req are level
// requests sampled every cycle; a request is acted on in the same cycle it
// is seen (outputs are Mealy), and there is no acknowledge back to the
// requester -- the enables/flush driven here are the acknowledgement.
module fetch_control
  import fetch_ctrl_pkg::*;
#(
  parameter int FLUSH_DEPTH = DEFAULT_FLUSH_DEPTH,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      PC_plus4,
  input  logic [63:0]      branch_target,
  input  logic             branch_taken,
  input  logic             hazard_stall,
  input  logic             halt_req,
  output logic [63:0]      next_PC,
  output logic             PC_enable,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             fetch_valid,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count,
  output state_t           fsm_state
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_DEPTH - 1);
  localparam state_t REDIRECT_NEXT = (FLUSH_DEPTH > 1) ? REDIRECT : RUN;

  state_t                 state;
  state_t                 state_nxt;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic [FLUSH_CNT_W-1:0] flush_nxt;
  logic                   stall_inc;
  logic                   redirect_inc;

  assign fsm_state = state;

  // Next-state, bubble counter and Mealy outputs from state plus requests.
  always_comb begin
    next_PC      = PC_plus4;
    PC_enable    = 1'b0;
    ifid_enable  = 1'b0;
    ifid_flush   = 1'b1;
    fetch_valid  = 1'b0;
    halted       = 1'b0;
    state_nxt    = state;
    flush_nxt    = flush_cnt;
    stall_inc    = 1'b0;
    redirect_inc = 1'b0;

    if (!reset) begin
      case (state)
        BOOT: begin
          state_nxt = RUN;
        end
        HALT: begin
          halted = 1'b1;
        end
        default: begin
          if (halt_req) begin
            halted    = 1'b1;
            state_nxt = HALT;
          end else if (branch_taken) begin
            // Redirect accepted: also restarts an in-progress flush window.
            next_PC      = branch_target;
            PC_enable    = 1'b1;
            ifid_enable  = 1'b1;
            redirect_inc = 1'b1;
            flush_nxt    = FLUSH_LOAD;
            state_nxt    = REDIRECT_NEXT;
          end else if (state == REDIRECT) begin
            // Decode holds bubbles here, so hazard_stall is not considered.
            PC_enable   = 1'b1;
            ifid_enable = 1'b1;
            if (flush_cnt <= FLUSH_CNT_W'(1)) begin
              flush_nxt = '0;
              state_nxt = RUN;
            end else begin
              flush_nxt = flush_cnt - FLUSH_CNT_W'(1);
            end
          end else if (hazard_stall) begin
            ifid_flush  = 1'b0;
            fetch_valid = 1'b1;
            stall_inc   = 1'b1;
            state_nxt   = STALL;
          end else begin
            PC_enable   = 1'b1;
            ifid_enable = 1'b1;
            ifid_flush  = 1'b0;
            fetch_valid = 1'b1;
            state_nxt   = RUN;
          end
        end
      endcase
    end
  end

  // State and bubble counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= BOOT;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redirect_inc),
    .count (redirect_count)
  );

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control (FLUSH_DEPTH=2, CNT_W=4).
module tb_fetch_control;
  import fetch_ctrl_pkg::*;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [63:0]   PC_plus4;
  logic [63:0]   branch_target;
  logic          branch_taken;
  logic          hazard_stall;
  logic          halt_req;
  logic [63:0]   next_PC;
  logic          PC_enable;
  logic          ifid_enable;
  logic          ifid_flush;
  logic          fetch_valid;
  logic          halted;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] redirect_count;
  state_t        fsm_state;

  int vectors;
  int miscompares;
  logic [63:0] exp_q[$];

  fetch_control #(.FLUSH_DEPTH(2), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .PC_plus4       (PC_plus4),
    .branch_target  (branch_target),
    .branch_taken   (branch_taken),
    .hazard_stall   (hazard_stall),
    .halt_req       (halt_req),
    .next_PC        (next_PC),
    .PC_enable      (PC_enable),
    .ifid_enable    (ifid_enable),
    .ifid_flush     (ifid_flush),
    .fetch_valid    (fetch_valid),
    .halted         (halted),
    .stall_cycles   (stall_cycles),
    .redirect_count (redirect_count),
    .fsm_state      (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled mid-cycle; inputs change just after the rising edge.
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic bt, input logic [63:0] tgt, input logic hz,
                       input logic hr, input logic [63:0] pc4);
    branch_taken  = bt;
    branch_target = tgt;
    hazard_stall  = hz;
    halt_req      = hr;
    PC_plus4      = pc4;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    drive(1'b1, 64'h999, 1'b1, 1'b1, 64'h4);
    advance();
    advance();

    // Reset overrides every request
    settle();
    check("rst_pc_en",   {63'd0, PC_enable},   64'd0);
    check("rst_ifid_en", {63'd0, ifid_enable}, 64'd0);
    check("rst_flush",   {63'd0, ifid_flush},  64'd1);
    check("rst_valid",   {63'd0, fetch_valid}, 64'd0);
    check("rst_halted",  {63'd0, halted},      64'd0);
    check("rst_next_pc", next_PC,              64'h4);
    check("rst_stall_cnt", {60'd0, stall_cycles},   64'd0);
    check("rst_redir_cnt", {60'd0, redirect_count}, 64'd0);
    advance();

    // BOOT cycle ignores requests
    reset = 1'b0;
    drive(1'b1, 64'h999, 1'b1, 1'b0, 64'h4);
    settle();
    check("boot_state", {61'd0, fsm_state}, {61'd0, BOOT});
    check("boot_pc_en", {63'd0, PC_enable}, 64'd0);
    check("boot_flush", {63'd0, ifid_flush}, 64'd1);
    check("boot_next_pc", next_PC, 64'h4);
    advance();

    // Free-running fetch: next_PC tracks PC_plus4
    exp_q.push_back(64'h4);
    exp_q.push_back(64'h8);
    exp_q.push_back(64'hc);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 64'h0, 1'b0, 1'b0, 64'(4 * (i + 1)));
      settle();
      check("run_next_pc", next_PC, exp_q.pop_front());
      check("run_pc_en", {63'd0, PC_enable}, 64'd1);
      check("run_flush", {63'd0, ifid_flush}, 64'd0);
      check("run_valid", {63'd0, fetch_valid}, 64'd1);
      advance();
    end

    // Redirect to 0x100 with two bubbles
    drive(1'b1, 64'h100, 1'b0, 1'b0, 64'h10);
    settle();
    check("br_next_pc", next_PC, 64'h100);
    check("br_pc_en", {63'd0, PC_enable}, 64'd1);
    check("br_flush", {63'd0, ifid_flush}, 64'd1);
    check("br_valid", {63'd0, fetch_valid}, 64'd0);
    advance();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h104);
    settle();
    check("redir_state", {61'd0, fsm_state}, {61'd0, REDIRECT});
    check("redir_flush", {63'd0, ifid_flush}, 64'd1);
    check("redir_pc_en", {63'd0, PC_enable}, 64'd1);
    check("redir_next_pc", next_PC, 64'h104);
    advance();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h108);
    settle();
    check("post_br_state", {61'd0, fsm_state}, {61'd0, RUN});
    check("post_br_flush", {63'd0, ifid_flush}, 64'd0);
    check("post_br_redir_cnt", {60'd0, redirect_count}, 64'd1);
    advance();

    // Three-cycle hazard stall
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h10c);
      settle();
      check("stall_pc_en", {63'd0, PC_enable}, 64'd0);
      check("stall_ifid_en", {63'd0, ifid_enable}, 64'd0);
      check("stall_flush", {63'd0, ifid_flush}, 64'd0);
      check("stall_valid", {63'd0, fetch_valid}, 64'd1);
      advance();
    end
    drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h10c);
    settle();
    check("resume_pc_en", {63'd0, PC_enable}, 64'd1);
    check("resume_next_pc", next_PC, 64'h10c);
    check("resume_stall_cnt", {60'd0, stall_cycles}, 64'd3);
    advance();

    // Stall and redirect together: redirect wins
    drive(1'b1, 64'h40, 1'b1, 1'b0, 64'h110);
    settle();
    check("both_next_pc", next_PC, 64'h40);
    check("both_pc_en", {63'd0, PC_enable}, 64'd1);
    check("both_flush", {63'd0, ifid_flush}, 64'd1);
    advance();

    // Redirect during REDIRECT restarts the window
    drive(1'b1, 64'h80, 1'b0, 1'b0, 64'h44);
    settle();
    check("rebr_state", {61'd0, fsm_state}, {61'd0, REDIRECT});
    check("rebr_next_pc", next_PC, 64'h80);
    check("both_stall_cnt", {60'd0, stall_cycles}, 64'd3);
    advance();

    // hazard_stall ignored while flushing
    drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h84);
    settle();
    check("redir_hz_state", {61'd0, fsm_state}, {61'd0, REDIRECT});
    check("redir_hz_pc_en", {63'd0, PC_enable}, 64'd1);
    check("redir_hz_flush", {63'd0, ifid_flush}, 64'd1);
    check("redir_hz_valid", {63'd0, fetch_valid}, 64'd0);
    advance();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h88);
    settle();
    check("rebr_exit_state", {61'd0, fsm_state}, {61'd0, RUN});
    check("rebr_stall_cnt", {60'd0, stall_cycles}, 64'd3);
    check("rebr_redir_cnt", {60'd0, redirect_count}, 64'd3);
    advance();

    // Halt arriving during STALL is immediate and sticky
    drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h88);
    advance();
    drive(1'b0, 64'h0, 1'b1, 1'b1, 64'h88);
    settle();
    check("halt_from_state", {61'd0, fsm_state}, {61'd0, STALL});
    check("halt_now", {63'd0, halted}, 64'd1);
    check("halt_pc_en", {63'd0, PC_enable}, 64'd0);
    check("halt_flush", {63'd0, ifid_flush}, 64'd1);
    check("halt_valid", {63'd0, fetch_valid}, 64'd0);
    advance();
    drive(1'b1, 64'h200, 1'b1, 1'b0, 64'h8c);
    settle();
    check("halt_sticky", {63'd0, halted}, 64'd1);
    check("halt_state", {61'd0, fsm_state}, {61'd0, HALT});
    check("halt_next_pc", next_PC, 64'h8c);
    check("halt_ign_pc_en", {63'd0, PC_enable}, 64'd0);
    advance();
    settle();
    check("halt_redir_cnt", {60'd0, redirect_count}, 64'd3);
    check("halt_still", {63'd0, halted}, 64'd1);

    // Reset leaves HALT and clears counters
    reset = 1'b1;
    advance();
    reset = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h4);
    settle();
    check("rerst_state", {61'd0, fsm_state}, {61'd0, BOOT});
    check("rerst_halted", {63'd0, halted}, 64'd0);
    check("rerst_stall_cnt", {60'd0, stall_cycles}, 64'd0);
    check("rerst_redir_cnt", {60'd0, redirect_count}, 64'd0);
    advance();

    // 20 stall cycles: counter saturates at 15
    drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h8);
    for (int i = 0; i < 20; i++) begin
      settle();
      check("sat_pc_en", {63'd0, PC_enable}, 64'd0);
      check("sat_stall_cnt", {60'd0, stall_cycles}, 64'((i > 15) ? 15 : i));
      advance();
    end
    drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h8);
    settle();
    check("sat_final_cnt", {60'd0, stall_cycles}, 64'd15);
    check("sat_resume_pc_en", {63'd0, PC_enable}, 64'd1);
    advance();

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
